// File: rtl/display_share_scheduler_pkg.sv
// Shared constants and types for the display share scheduler.
// Holds the source count, the FSM state encoding and a one-hot helper.
package disp_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/display_share_scheduler_if.sv
// Request/grant bundle between the requesting logic and the scheduler.
// master = requester side, slave = scheduler side.
interface display_share_scheduler_if;
  import disp_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic               hold;
  logic [SEL_W-1:0]   s;
  logic [NUM_SRC-1:0] grant;
  logic               blank;
  logic               switch_pulse;

  modport master (
    output req, hold,
    input  s, grant, blank, switch_pulse
  );

  modport slave (
    input  req, hold,
    output s, grant, blank, switch_pulse
  );

endinterface

// File: rtl/display_share_scheduler_rr_arb4.sv
// Combinational 4-way round-robin arbiter.
// Scans ptr+1, ptr+2, ptr+3, ptr (mod 4) and reports the first requester.
module rr_arb4
  import disp_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [SEL_W-1:0] cand [NUM_SRC];
  logic [NUM_SRC-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      assign cand[gi] = ptr + SEL_W'(gi + 1);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  assign any = |req;

  // Walk from lowest priority upward so the earliest hit is the last write.
  always_comb begin
    win = cand[0];
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (hit[k]) win = cand[k];
    end
  end

endmodule

// File: rtl/display_share_scheduler.sv
// Time-shares one mux/7-segment decoder path between four requesters
// using round-robin arbitration with a programmable dwell time.
module display_share_scheduler
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  display_share_scheduler_if.slave    bus
);

  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [SEL_W-1:0]   s_reg, s_next;
  logic [NUM_SRC-1:0] grant_reg, grant_next;
  logic               blank_reg, blank_next;
  logic               pulse_reg, pulse_next;

  logic               arb_any;
  logic [SEL_W-1:0]   arb_win;
  logic               event_rearb;

  rr_arb4 u_arb (
    .req (bus.req),
    .ptr (ptr_reg),
    .any (arb_any),
    .win (arb_win)
  );

  // A dropped request wins over hold; dwell expiry only counts when not held.
  assign event_rearb = !bus.req[s_reg] || (!bus.hold && (count_reg == CNT_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      ptr_reg   <= SEL_W'(NUM_SRC - 1);
      s_reg     <= '0;
      grant_reg <= '0;
      blank_reg <= 1'b1;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ptr_reg   <= ptr_next;
      s_reg     <= s_next;
      grant_reg <= grant_next;
      blank_reg <= blank_next;
      pulse_reg <= pulse_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ptr_next   = ptr_reg;
    s_next     = s_reg;
    grant_next = grant_reg;
    blank_next = blank_reg;
    pulse_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          state_next = ST_SHOW;
          count_next = '0;
          ptr_next   = arb_win;
          s_next     = arb_win;
          grant_next = onehot(arb_win);
          blank_next = 1'b0;
          pulse_next = 1'b1;
        end
      end
      ST_SHOW: begin
        if (event_rearb) begin
          count_next = '0;
          if (!arb_any) begin
            state_next = ST_IDLE;
            grant_next = '0;
            blank_next = 1'b1;
          end else if (arb_win != s_reg) begin
            ptr_next   = arb_win;
            s_next     = arb_win;
            grant_next = onehot(arb_win);
            pulse_next = 1'b1;
          end
          // Otherwise the sole requester is the current one: keep it.
        end else if (!bus.hold) begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.s            = s_reg;
  assign bus.grant        = grant_reg;
  assign bus.blank        = blank_reg;
  assign bus.switch_pulse = pulse_reg;

endmodule

// File: tb/tb_display_share_scheduler.sv
// Directed bench for display_share_scheduler with a 4-cycle dwell.
module tb_display_share_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  display_share_scheduler_if bus ();

  display_share_scheduler #(.DWELL_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset_rotation();
    logic [3:0] exp_g;
    logic [1:0] exp_s;
    bus.req  = 4'b1111;
    bus.hold = 1'b0;
    reset    = 1'b1;
    tick();
    checks++;
    if (bus.s !== 2'd0 || bus.grant !== 4'b0000 || bus.blank !== 1'b1 || bus.switch_pulse !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: s=%0d grant=%b blank=%b pulse=%b, required s=0 grant=0000 blank=1 pulse=0",
               bus.s, bus.grant, bus.blank, bus.switch_pulse);
    end
    reset = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_s = 2'(k % 4);
      exp_g = 4'b0001 << exp_s;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (bus.grant !== exp_g || bus.s !== exp_s || bus.blank !== 1'b0 ||
            bus.switch_pulse !== (c == 0)) begin
          fails++;
          $display("FAIL rotation k=%0d c=%0d: grant=%b s=%0d blank=%b pulse=%b, required grant=%b s=%0d blank=0 pulse=%0d",
                   k, c, bus.grant, bus.s, bus.blank, bus.switch_pulse, exp_g, exp_s, (c == 0));
        end
        $display("rotation k=%0d c=%0d grant=%b pulse=%b", k, c, bus.grant, bus.switch_pulse);
        tick();
      end
    end
  endtask

  task automatic test_single_req();
    bus.req  = 4'b0100;
    bus.hold = 1'b0;
    pulse_reset();
    tick();
    for (int c = 0; c < 13; c++) begin
      checks++;
      if (bus.grant !== 4'b0100 || bus.s !== 2'd2 || bus.switch_pulse !== (c == 0) ||
          int'(dut.count_reg) !== (c % 4)) begin
        fails++;
        $display("FAIL single_req c=%0d: grant=%b s=%0d pulse=%b count=%0d, required grant=0100 s=2 pulse=%0d count=%0d",
                 c, bus.grant, bus.s, bus.switch_pulse, dut.count_reg, (c == 0), c % 4);
      end
      $display("single_req c=%0d grant=%b count=%0d", c, bus.grant, dut.count_reg);
      tick();
    end
  endtask

  task automatic test_hold();
    bus.req  = 4'b0011;
    bus.hold = 1'b0;
    pulse_reset();
    tick();
    bus.hold = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0001 || bus.switch_pulse !== 1'b0) begin
        fails++;
        $display("FAIL hold_freeze c=%0d: grant=%b pulse=%b, required grant=0001 pulse=0",
                 c, bus.grant, bus.switch_pulse);
      end
      $display("hold c=%0d grant=%b", c, bus.grant);
    end
    bus.hold = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (c < 3) begin
        if (bus.grant !== 4'b0001) begin
          fails++;
          $display("FAIL hold_remaining c=%0d: grant=%b, required 0001", c, bus.grant);
        end
      end else if (bus.grant !== 4'b0010 || bus.switch_pulse !== 1'b1) begin
        fails++;
        $display("FAIL hold_release: grant=%b pulse=%b, required grant=0010 pulse=1",
                 bus.grant, bus.switch_pulse);
      end
      $display("hold_release c=%0d grant=%b", c, bus.grant);
    end
  endtask

  task automatic test_drop_on_final();
    int pulses;
    bus.req  = 4'b1010;
    bus.hold = 1'b0;
    pulse_reset();
    tick();
    checks++;
    if (bus.grant !== 4'b0010) begin
      fails++;
      $display("FAIL drop_setup: grant=%b, required 0010", bus.grant);
    end
    tick();
    tick();
    tick();
    bus.req = 4'b1000;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.switch_pulse === 1'b1) pulses++;
      checks++;
      if (bus.grant !== 4'b1000 || bus.s !== 2'd3) begin
        fails++;
        $display("FAIL drop_grant c=%0d: grant=%b s=%0d, required grant=1000 s=3", c, bus.grant, bus.s);
      end
    end
    checks++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL drop_pulses: pulses=%0d, required 1", pulses);
    end
    $display("drop_on_final pulses=%0d grant=%b", pulses, bus.grant);
  endtask

  task automatic test_idle_return();
    bus.req  = 4'b1000;
    bus.hold = 1'b0;
    pulse_reset();
    tick();
    checks++;
    if (bus.grant !== 4'b1000 || bus.s !== 2'd3) begin
      fails++;
      $display("FAIL idle_setup: grant=%b s=%0d, required grant=1000 s=3", bus.grant, bus.s);
    end
    bus.req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0000 || bus.blank !== 1'b1 || bus.s !== 2'd3 || bus.switch_pulse !== 1'b0) begin
        fails++;
        $display("FAIL idle_blank c=%0d: grant=%b blank=%b s=%0d pulse=%b, required grant=0000 blank=1 s=3 pulse=0",
                 c, bus.grant, bus.blank, bus.s, bus.switch_pulse);
      end
    end
    bus.req = 4'b0001;
    tick();
    checks++;
    if (bus.grant !== 4'b0001 || bus.s !== 2'd0 || bus.blank !== 1'b0 || bus.switch_pulse !== 1'b1) begin
      fails++;
      $display("FAIL idle_regrant: grant=%b s=%0d blank=%b pulse=%b, required grant=0001 s=0 blank=0 pulse=1",
               bus.grant, bus.s, bus.blank, bus.switch_pulse);
    end
    $display("idle_return grant=%b s=%0d", bus.grant, bus.s);
  endtask

  task automatic test_async_reset();
    bus.req  = 4'b1111;
    bus.hold = 1'b0;
    pulse_reset();
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (bus.grant !== 4'b0010) begin
      fails++;
      $display("FAIL async_setup: grant=%b, required 0010", bus.grant);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.s !== 2'd0 || bus.grant !== 4'b0000 || bus.blank !== 1'b1 || bus.switch_pulse !== 1'b0 ||
        dut.ptr_reg !== 2'd3 || int'(dut.count_reg) !== 0) begin
      fails++;
      $display("FAIL async_reset: s=%0d grant=%b blank=%b pulse=%b ptr=%0d count=%0d, required s=0 grant=0000 blank=1 pulse=0 ptr=3 count=0",
               bus.s, bus.grant, bus.blank, bus.switch_pulse, dut.ptr_reg, dut.count_reg);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 4'b0001 || bus.switch_pulse !== 1'b1) begin
      fails++;
      $display("FAIL async_next_winner: grant=%b pulse=%b, required grant=0001 pulse=1",
               bus.grant, bus.switch_pulse);
    end
    $display("async_reset next grant=%b", bus.grant);
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    reset    = 1'b1;
    bus.req  = 4'b0000;
    bus.hold = 1'b0;
    test_reset_rotation();
    test_single_req();
    test_hold();
    test_drop_on_final();
    test_idle_return();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
